// File: rtl/nmi_sched.sv
// Multi-source NMI scheduler: latches per-source requests, grants one at a time by fixed
// priority, pulses the generator request line and tracks entry, exit, timeout and holdoff.
module nmi_sched #(
    parameter int NSRC           = 4,
    parameter int CAUSE_W        = 2,
    parameter int TMO_FRAMES     = 3,
    parameter int HOLDOFF_FRAMES = 1
) (
    input  logic               fclk,
    input  logic               rst,
    input  logic [NSRC-1:0]    src_req,
    input  logic [NSRC-1:0]    src_mask,
    input  logic               int_start,
    input  logic               in_nmi,
    input  logic               cause_ack,
    input  logic               err_clr,
    output logic               set_nmi,
    output logic               busy,
    output logic [NSRC-1:0]    pend,
    output logic [CAUSE_W-1:0] cause,
    output logic               cause_vld,
    output logic               tmo_err
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_ENTRY = 2'd2,
        S_SERVICE    = 2'd3
    } state_t;

    localparam logic [3:0] TMO_L  = 4'(TMO_FRAMES);
    localparam logic [3:0] HOLD_L = 4'(HOLDOFF_FRAMES);

    state_t              state_q, state_d;
    logic [NSRC-1:0]     pend_q, pend_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic                cause_vld_q, cause_vld_d;
    logic                tmo_err_q, tmo_err_d;
    logic                set_nmi_q, set_nmi_d;
    logic                issue_q, issue_d;
    logic [3:0]          holdoff_q, holdoff_d;
    logic [3:0]          frame_q, frame_d;

    logic [NSRC-1:0]     grant_sel, grant_oh;
    logic [CAUSE_W-1:0]  grant_idx;
    logic                found;
    logic                vld_set, tmo_set;
    logic [3:0]          frame_inc;

    // Lowest set index of pend wins.
    always_comb begin
        grant_sel = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend_q[i] && !found) begin
                found        = 1'b1;
                grant_sel[i] = 1'b1;
                grant_idx    = CAUSE_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        set_nmi_d = set_nmi_q;
        issue_d   = issue_q;
        holdoff_d = holdoff_q;
        frame_d   = frame_q;
        grant_oh  = '0;
        vld_set   = 1'b0;
        tmo_set   = 1'b0;
        frame_inc = (frame_q == 4'hF) ? 4'hF : frame_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (int_start && holdoff_q != 4'd0) holdoff_d = holdoff_q - 4'd1;
                if (found && holdoff_q == 4'd0 && !in_nmi) begin
                    grant_oh  = grant_sel;
                    cause_d   = grant_idx;
                    set_nmi_d = 1'b1;
                    issue_d   = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Grant cycle plus one more; the falling edge is what the generator acts on.
                if (!issue_q) begin
                    issue_d = 1'b1;
                end else begin
                    set_nmi_d = 1'b0;
                    frame_d   = 4'd0;
                    state_d   = S_WAIT_ENTRY;
                end
            end
            S_WAIT_ENTRY: begin
                if (in_nmi) begin
                    vld_set = 1'b1;
                    state_d = S_SERVICE;
                end else if (int_start) begin
                    frame_d = frame_inc;
                    if (frame_inc >= TMO_L) begin
                        tmo_set   = 1'b1;
                        holdoff_d = HOLD_L;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_SERVICE: begin
                if (!in_nmi) begin
                    holdoff_d = HOLD_L;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_d      = ((pend_q & ~grant_oh) | src_req) & ~src_mask;
        cause_vld_d = vld_set ? 1'b1 : (cause_ack ? 1'b0 : cause_vld_q);
        tmo_err_d   = tmo_set ? 1'b1 : (err_clr ? 1'b0 : tmo_err_q);
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            cause_q     <= '0;
            cause_vld_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            set_nmi_q   <= 1'b0;
            issue_q     <= 1'b0;
            holdoff_q   <= 4'd0;
            frame_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cause_q     <= cause_d;
            cause_vld_q <= cause_vld_d;
            tmo_err_q   <= tmo_err_d;
            set_nmi_q   <= set_nmi_d;
            issue_q     <= issue_d;
            holdoff_q   <= holdoff_d;
            frame_q     <= frame_d;
        end
    end

    assign set_nmi   = set_nmi_q;
    assign busy      = (state_q != S_IDLE);
    assign pend      = pend_q;
    assign cause     = cause_q;
    assign cause_vld = cause_vld_q;
    assign tmo_err   = tmo_err_q;

endmodule
